// File: rtl/pmem_scheduler.sv
// pmem_scheduler: shares one physical-memory line port between the I-cache
// and the D-cache. Requests are granted round-robin, the winning request is
// latched and pmem is driven only from those registers, and the returned line
// goes back to the winner with a registered one-cycle completion pulse.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_addr, i_read             I-cache miss request (level, held until i_resp)
//   i_rdata, i_resp            line and completion pulse back to the I-cache
//   d_addr, d_wdata            D-cache address and write-back line
//   d_read, d_write            D-cache requests (level; read wins if both set)
//   d_rdata, d_resp            line and completion pulse back to the D-cache
//   pm_addr, pm_wdata          pmem address (line aligned) and write line
//   pm_read, pm_write          pmem strobes (level, held until pm_resp)
//   pm_rdata, pm_resp          pmem read line and completion
//
// Optional build macro PMEM_SCHED_STATS_EN adds parameter CNT_W and the
// stat_i_grants / stat_d_grants / stat_busy_cyc counters with a synchronous
// stat_clr input. Without it the block has no statistics logic.
module pmem_scheduler #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
`ifdef PMEM_SCHED_STATS_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PMEM_SCHED_STATS_EN
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_i_grants,
  output logic [CNT_W-1:0]  stat_d_grants,
  output logic [CNT_W-1:0]  stat_busy_cyc,
`endif
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic              d_read,
  input  logic              d_write,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [LINE_W-1:0] pm_wdata,
  output logic              pm_read,
  output logic              pm_write,
  input  logic [LINE_W-1:0] pm_rdata,
  input  logic              pm_resp
);

  localparam int unsigned OFS_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // last_d_q: 1 when the most recent grant went to the D side
  logic last_d_q;
  logic owner_d_q;
  logic op_wr_q;

  logic              grant_c;
  logic              gnt_d_c;
  logic              fin_c;
  logic              wr_c;
  logic [ADDR_W-1:0] sel_addr_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, arbitration and transaction-complete decode
  always_comb begin
    state_d    = state_q;
    grant_c    = 1'b0;
    gnt_d_c    = 1'b0;
    fin_c      = 1'b0;
    wr_c       = 1'b0;
    sel_addr_c = i_addr;
    case (state_q)
      IDLE: begin
        if (i_read || d_read || d_write) begin
          grant_c = 1'b1;
          // D wins when alone, or on a tie when I was served last
          gnt_d_c = (d_read || d_write) && (!i_read || !last_d_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pm_resp) begin
          fin_c   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Gap cycle so the winner can drop its level request
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wr_c       = gnt_d_c && d_write && !d_read;
    sel_addr_c = gnt_d_c ? d_addr : i_addr;
  end

  // Latched request and pmem drive; strobes fall on the edge that sees pm_resp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q  <= 1'b1;
      owner_d_q <= 1'b0;
      op_wr_q   <= 1'b0;
      pm_addr   <= '0;
      pm_wdata  <= '0;
      pm_read   <= 1'b0;
      pm_write  <= 1'b0;
    end else if (grant_c) begin
      last_d_q  <= gnt_d_c;
      owner_d_q <= gnt_d_c;
      op_wr_q   <= wr_c;
      pm_addr   <= sel_addr_c & ~OFS_MASK;
      pm_wdata  <= gnt_d_c ? d_wdata : '0;
      pm_read   <= !wr_c;
      pm_write  <= wr_c;
    end else if (fin_c) begin
      pm_read   <= 1'b0;
      pm_write  <= 1'b0;
    end
  end

  // Completion pulse and returned line; both are zero outside the RESP cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_resp  <= 1'b0;
      d_resp  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_resp  <= fin_c && !owner_d_q;
      d_resp  <= fin_c && owner_d_q;
      i_rdata <= (fin_c && !owner_d_q && !op_wr_q) ? pm_rdata : '0;
      d_rdata <= (fin_c && owner_d_q && !op_wr_q) ? pm_rdata : '0;
    end
  end

`ifdef PMEM_SCHED_STATS_EN
  // Statistics counters; clear wins over increment, all wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_i_grants <= '0;
      stat_d_grants <= '0;
      stat_busy_cyc <= '0;
    end else if (stat_clr) begin
      stat_i_grants <= '0;
      stat_d_grants <= '0;
      stat_busy_cyc <= '0;
    end else begin
      if (grant_c && !gnt_d_c) stat_i_grants <= stat_i_grants + CNT_W'(1);
      if (grant_c && gnt_d_c)  stat_d_grants <= stat_d_grants + CNT_W'(1);
      if (state_q == BUSY)     stat_busy_cyc <= stat_busy_cyc + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pmem_scheduler.sv
// Testbench for pmem_scheduler: randomized and directed requester traffic
// against a transaction-level reference model and a simple pmem responder.
module tb_pmem_scheduler;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned CNT_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_read = 1'b0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] pm_addr;
  logic [LINE_W-1:0] pm_wdata;
  logic              pm_read;
  logic              pm_write;
  logic [LINE_W-1:0] pm_rdata = '0;
  logic              pm_resp = 1'b0;
  logic              stat_clr = 1'b0;
`ifdef PMEM_SCHED_STATS_EN
  logic [CNT_W-1:0]  stat_i_grants;
  logic [CNT_W-1:0]  stat_d_grants;
  logic [CNT_W-1:0]  stat_busy_cyc;
`endif

  pmem_scheduler #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
`ifdef PMEM_SCHED_STATS_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef PMEM_SCHED_STATS_EN
    .stat_clr      (stat_clr),
    .stat_i_grants (stat_i_grants),
    .stat_d_grants (stat_d_grants),
    .stat_busy_cyc (stat_busy_cyc),
`endif
    .i_addr        (i_addr),
    .i_read        (i_read),
    .i_rdata       (i_rdata),
    .i_resp        (i_resp),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_rdata       (d_rdata),
    .d_resp        (d_resp),
    .pm_addr       (pm_addr),
    .pm_wdata      (pm_wdata),
    .pm_read       (pm_read),
    .pm_write      (pm_write),
    .pm_rdata      (pm_rdata),
    .pm_resp       (pm_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction at most; a new grant is
  // possible from m_free_at on (two edges after the completing edge).
  bit               m_active = 1'b0;
  bit               m_owner  = 1'b0;   // 1 = D side
  bit               m_last   = 1'b1;   // 1 = D side served last
  bit               m_wr     = 1'b0;
  logic [31:0]      m_addr   = '0;
  logic [255:0]     m_wdata  = '0;
  int               m_free_at = 0;
  int               edge_n = 0;
  int               strobe_cnt = 0;
  int               cur_lat = 0;
  int               lat_fixed = -1;
  bit               exp_i_resp = 1'b0;
  bit               exp_d_resp = 1'b0;
  logic [255:0]     exp_i_rdata = '0;
  logic [255:0]     exp_d_rdata = '0;
  bit               gnt_log[$];
  int unsigned      st_i = 0;
  int unsigned      st_d = 0;
  int unsigned      st_b = 0;

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_update(input logic s_ir, input logic s_dr, input logic s_dw,
                              input logic [31:0] s_ia, input logic [31:0] s_da,
                              input logic [255:0] s_dwd, input logic s_pr,
                              input logic [255:0] s_prd, input logic s_clr);
    bit was_busy;
    bit gi;
    bit gd;
    was_busy = m_active;
    gi = 1'b0;
    gd = 1'b0;
    exp_i_resp = 1'b0;
    exp_d_resp = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    if (m_active) begin
      if (s_pr) begin
        m_active = 1'b0;
        m_free_at = edge_n + 2;
        if (m_owner) begin
          exp_d_resp = 1'b1;
          exp_d_rdata = m_wr ? 256'd0 : s_prd;
        end else begin
          exp_i_resp = 1'b1;
          exp_i_rdata = s_prd;
        end
      end
    end else if (edge_n >= m_free_at && (s_ir || s_dr || s_dw)) begin
      if (s_ir && (s_dr || s_dw)) m_owner = !m_last;
      else m_owner = !s_ir;
      m_last = m_owner;
      m_active = 1'b1;
      m_wr = m_owner && s_dw && !s_dr;
      m_addr = m_owner ? s_da : s_ia;
      m_wdata = s_dwd;
      strobe_cnt = 0;
      cur_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
      gnt_log.push_back(m_owner);
      gi = !m_owner;
      gd = m_owner;
    end
    if (s_clr) begin
      st_i = 0;
      st_d = 0;
      st_b = 0;
    end else begin
      st_i = st_i + 32'(gi);
      st_d = st_d + 32'(gd);
      st_b = st_b + 32'(was_busy);
    end
  endtask

  task automatic compare();
    check("pm_read", 256'(pm_read), 256'(m_active && !m_wr));
    check("pm_write", 256'(pm_write), 256'(m_active && m_wr));
    if (m_active) check("pm_addr", 256'(pm_addr), 256'((m_addr / 32'd32) * 32'd32));
    if (m_active && m_wr) check("pm_wdata", pm_wdata, m_wdata);
    check("i_resp", 256'(i_resp), 256'(exp_i_resp));
    check("d_resp", 256'(d_resp), 256'(exp_d_resp));
    check("i_rdata", i_rdata, exp_i_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
`ifdef PMEM_SCHED_STATS_EN
    check("stat_i", 256'(stat_i_grants), 256'(st_i));
    check("stat_d", 256'(stat_d_grants), 256'(st_d));
    check("stat_busy", 256'(stat_busy_cyc), 256'(st_b));
`endif
  endtask

  // pmem responder: completes L+1 strobe cycles after the grant, and throws
  // in stray pm_resp pulses when nothing is outstanding.
  task automatic pmem_drive();
    pm_rdata = rnd_line();
    if (m_active) begin
      strobe_cnt++;
      pm_resp = (strobe_cnt == cur_lat + 1);
    end else begin
      pm_resp = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic cycle();
    logic s_ir, s_dr, s_dw, s_pr, s_clr;
    logic [31:0] s_ia, s_da;
    logic [255:0] s_dwd, s_prd;
    s_ir = i_read; s_dr = d_read; s_dw = d_write; s_pr = pm_resp; s_clr = stat_clr;
    s_ia = i_addr; s_da = d_addr; s_dwd = d_wdata; s_prd = pm_rdata;
    @(posedge clk);
    #1;
    edge_n++;
    model_update(s_ir, s_dr, s_dw, s_ia, s_da, s_dwd, s_pr, s_prd, s_clr);
    compare();
    pmem_drive();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pm_read"}, 256'(pm_read), 256'(0));
    check({tag, "_pm_write"}, 256'(pm_write), 256'(0));
    check({tag, "_resp"}, 256'({i_resp, d_resp}), 256'(0));
    check({tag, "_rdata"}, i_rdata | d_rdata, 256'(0));
    check({tag, "_pm_addr"}, 256'(pm_addr), 256'(0));
`ifdef PMEM_SCHED_STATS_EN
    check({tag, "_stats"}, 256'(stat_i_grants | stat_d_grants | stat_busy_cyc), 256'(0));
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pm_resp = 1'b0; stat_clr = 1'b0;
    #1;
    check_all_zero("rst_async");
    m_active = 1'b0; m_last = 1'b1;
    exp_i_resp = 1'b0; exp_d_resp = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    st_i = 0; st_d = 0; st_b = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      edge_n++;
      check_all_zero("rst_hold");
    end
    rst_n = 1'b1;
    m_free_at = edge_n + 1;
  endtask

  // Drop all requests and let any outstanding transaction drain
  task automatic quiesce();
    int k;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    k = 0;
    while ((m_active || k < 4) && k < 100) begin
      cycle();
      k++;
    end
    check("quiesce_idle", 256'(m_active), 256'(0));
  endtask

  // One request from a single side, waited on to completion
  task automatic single_txn(input bit side_d, input bit wr, input int lat);
    bit done;
    lat_fixed = lat;
    done = 1'b0;
    if (side_d) begin
      d_addr = $urandom; d_wdata = rnd_line(); d_read = !wr; d_write = wr;
    end else begin
      i_addr = $urandom; i_read = 1'b1;
    end
    for (int k = 0; k < 60 && !done; k++) begin
      cycle();
      if (side_d ? exp_d_resp : exp_i_resp) begin
        done = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end
    end
    check("single_done", 256'(done), 256'(1));
    cycle();
  endtask

  task automatic rand_req();
    if (exp_i_resp) i_read = 1'($urandom_range(0, 1));
    else if (!i_read) i_read = ($urandom_range(0, 3) == 0);
    else if ($urandom_range(0, 31) == 0) i_read = 1'b0;
    if ($urandom_range(0, 3) == 0) i_addr = $urandom;
    if (exp_d_resp && $urandom_range(0, 1) == 0) begin
      d_read = 1'b0; d_write = 1'b0;
    end else if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 2))
        0: begin d_read = 1'b1; d_write = 1'b0; end
        1: begin d_read = 1'b0; d_write = 1'b1; end
        default: begin d_read = 1'b1; d_write = 1'b1; end
      endcase
    end else if ((d_read || d_write) && $urandom_range(0, 31) == 0) begin
      d_read = 1'b0; d_write = 1'b0;
    end
    if ($urandom_range(0, 3) == 0) d_addr = $urandom;
    if ($urandom_range(0, 3) == 0) d_wdata = rnd_line();
    stat_clr = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    int t0, rd_cnt, resp_edge, base, pulses;
    bit i_done, d_done;

    #1;
    apply_reset();

    // Single I read, L=4: strobe for 5 cycles, completion 6 edges after request
    i_read = 1'b1; i_addr = 32'h0000_1234; lat_fixed = 4;
    t0 = edge_n; rd_cnt = 0; resp_edge = -1;
    for (int k = 0; k < 40 && resp_edge < 0; k++) begin
      cycle();
      if (pm_read) begin
        rd_cnt++;
        check("single_pm_addr", 256'(pm_addr), 256'(32'h0000_1220));
      end
      if (i_resp) begin
        resp_edge = edge_n;
        i_read = 1'b0;
      end
    end
    check("single_rd_cycles", 256'(rd_cnt), 256'(5));
    check("single_latency", 256'(resp_edge - t0), 256'(6));
    quiesce();

    // Collision straight out of reset: I first, then the D write-back
    apply_reset();
    base = gnt_log.size();
    lat_fixed = -1;
    i_read = 1'b1; i_addr = $urandom;
    d_write = 1'b1; d_addr = $urandom; d_wdata = rnd_line();
    i_done = 1'b0; d_done = 1'b0;
    for (int k = 0; k < 100 && !(i_done && d_done); k++) begin
      cycle();
      if (exp_i_resp) begin i_done = 1'b1; i_read = 1'b0; end
      if (exp_d_resp) begin d_done = 1'b1; d_write = 1'b0; end
    end
    check("collide_done", 256'({i_done, d_done}), 256'(2'b11));
    if (gnt_log.size() >= base + 2) begin
      check("collide_first", 256'(gnt_log[base]), 256'(0));
      check("collide_second", 256'(gnt_log[base + 1]), 256'(1));
    end
    quiesce();

    // Continuous contention: both sides held for 8 grants must alternate
    base = gnt_log.size();
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 400 && gnt_log.size() < base + 8; k++) begin
      cycle();
      i_addr = $urandom; d_addr = $urandom;
    end
    check("alt_count", 256'(gnt_log.size() >= base + 8), 256'(1));
    for (int k = 0; k < 8 && base + k < gnt_log.size(); k++)
      check("alt_order", 256'(gnt_log[base + k]), 256'(k % 2));
    quiesce();

    // Abandon: D drops its read while the transaction is in flight
    d_read = 1'b1; d_addr = $urandom; lat_fixed = 3; pulses = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (m_active) d_read = 1'b0;
      if (d_resp) pulses++;
    end
    check("abandon_pulses", 256'(pulses), 256'(1));
    quiesce();

`ifdef PMEM_SCHED_STATS_EN
    // Statistics: 3 I and 2 D grants with L=2, then clear
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    for (int n = 0; n < 5; n++) single_txn(n >= 3, 1'b0, 2);
    check("stats_i3", 256'(stat_i_grants), 256'(3));
    check("stats_d2", 256'(stat_d_grants), 256'(2));
    check("stats_busy15", 256'(stat_busy_cyc), 256'(15));
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    check("stats_clr", 256'(stat_i_grants | stat_d_grants | stat_busy_cyc), 256'(0));
`else
    single_txn(1'b1, 1'b1, 2);
    single_txn(1'b0, 1'b0, 0);
`endif

    // Randomized traffic
    lat_fixed = -1;
    for (int k = 0; k < 3000; k++) begin
      cycle();
      rand_req();
    end
    stat_clr = 1'b0;
    quiesce();

    // Reset while BUSY: strobe drops at once, no completion afterwards
    i_read = 1'b1; i_addr = $urandom; lat_fixed = 10;
    for (int k = 0; k < 20 && !m_active; k++) cycle();
    cycle();
    check("midbusy_pm_read", 256'(pm_read), 256'(1));
    apply_reset();
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (i_resp || d_resp) pulses++;
    end
    check("midbusy_no_resp", 256'(pulses), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
